// File: rtl/alu381_serial.sv
// Digit-serial 74381-style ALU: one 4-bit slice per clock, LSB slice first, start/busy/done handshake.
// Optional accumulator chaining (acc_sel port) is compiled in when ALU_ACC_EN is defined.
module alu381_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ALU_ACC_EN
    input  logic             acc_sel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam int N     = WIDTH / 4;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q, shadow_q, shadow_next, result_q;
    logic [WIDTH-1:0] a_src;
    logic [2:0]       s_q;
    logic             carry_q, cout_q, zero_q;
    logic [CNT_W-1:0] k_q;
    logic [CNT_W+1:0] base;
    logic             accept, step, last_slice;
    logic [3:0]       a_sl, b_sl, f_sl;
    logic [4:0]       sum;
    logic             c_sl;

`ifdef ALU_ACC_EN
    assign a_src = acc_sel ? result_q : a;
`else
    assign a_src = a;
`endif

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    assign last_slice = (k_q == CNT_W'(N - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        done   = (state == DONE);
        step   = (state == RUN);
        accept = start && (state != RUN);
    end

    // Slice k occupies bits 4k+3..4k of the latched operands.
    assign base = {k_q, 2'b00};
    assign a_sl = a_q[base +: 4];
    assign b_sl = b_q[base +: 4];

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        sum  = '0;
        f_sl = '0;
        c_sl = 1'b0;
        case (s_q)
            3'b000: f_sl = 4'h0;
            3'b001: begin
                sum  = {1'b0, b_sl} + {1'b0, ~a_sl} + {4'd0, carry_q};
                f_sl = sum[3:0];
                c_sl = sum[4];
            end
            3'b010: begin
                sum  = {1'b0, a_sl} + {1'b0, ~b_sl} + {4'd0, carry_q};
                f_sl = sum[3:0];
                c_sl = sum[4];
            end
            3'b011: begin
                sum  = {1'b0, a_sl} + {1'b0, b_sl} + {4'd0, carry_q};
                f_sl = sum[3:0];
                c_sl = sum[4];
            end
            3'b100:  f_sl = a_sl ^ b_sl;
            3'b101:  f_sl = a_sl | b_sl;
            3'b110:  f_sl = a_sl & b_sl;
            default: f_sl = 4'hF;
        endcase
    end

    always_comb begin
        shadow_next            = shadow_q;
        shadow_next[base +: 4] = f_sl;
    end

    // NOTE: operand, carry and shadow registers are reset too, so no stale operation survives rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            shadow_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            a_q      <= a_src;
            b_q      <= b;
            s_q      <= s;
            carry_q  <= cin;
            k_q      <= '0;
            shadow_q <= '0;
        end else if (step) begin
            shadow_q <= shadow_next;
            carry_q  <= c_sl;
            k_q      <= k_q + 1'b1;
            // Visible outputs move only on the final slice.
            if (last_slice) begin
                result_q <= shadow_next;
                cout_q   <= c_sl;
                zero_q   <= (shadow_next == '0);
            end
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

endmodule
